// File: rtl/pdh_cmd_pkg.sv
// Shared command, error and FSM definitions for the PDH command bank.
package pdh_cmd_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'h0,
        SET    = 4'h1,
        GET    = 4'h2,
        CLR    = 4'h3,
        STROBE = 4'hE
    } cmd_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_UNKNOWN = 2'd1,
        ERR_SEL     = 2'd2,
        ERR_DOUBLE  = 2'd3
    } err_e;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_EXEC = 2'd1;
    localparam state_t S_ACK  = 2'd2;

    localparam int CMD_LSB = 27;
    localparam int SEL_LSB = 24;
    localparam int RST_BIT = 31;
    localparam int CMD_W   = 4;

endpackage

// File: rtl/pdh_cmd_chan.sv
// One payload channel: shadow register, live register and pending flag.
module pdh_cmd_chan
    import pdh_cmd_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              srst,
    input  logic              wr_en,
    input  logic              commit,
    input  logic              clr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] live,
    output logic              pending,
    output logic              update
);

    logic [DATA_W-1:0] shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            live    <= '0;
            pending <= 1'b0;
            update  <= 1'b0;
        end else if (srst) begin
            shadow  <= '0;
            live    <= '0;
            pending <= 1'b0;
            update  <= 1'b0;
        end else begin
            update <= commit & pending;
            if (commit && pending) begin
                live    <= shadow;
                pending <= 1'b0;
            end
            if (clr)
                pending <= 1'b0;
            if (wr_en) begin
                shadow  <= data;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdh_cmd_bank.sv
// Decodes the PS control word into N_CH two-phase (SET/STROBE) payload channels
// and returns a status word with readback and sticky error flags.
module pdh_cmd_bank
    import pdh_cmd_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            axi_from_ps_i,
    output logic [31:0]            axi_to_ps_o,
    output logic [N_CH*DATA_W-1:0] ch_data_o,
    output logic [N_CH-1:0]        ch_update_o,
    output logic [N_CH-1:0]        pending_o
);

    localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

    logic [31:0]      in_r;
    logic [31:0]      prev_r;
    logic [31:0]      lat_r;
    state_t           state;
    logic             srst;
    logic             cmd_evt;
    logic [31:0]      exec_w;
    logic [CMD_W-1:0] cmd;
    logic [SEL_W-1:0] sel;
    logic             sel_bad;
    logic [N_CH-1:0]  sel_hot;
    logic [N_CH-1:0]  wr_en;
    logic             commit;
    logic             clr_all;
    logic             ok;
    logic             err;
    err_e             err_nxt;
    logic             get_en;
    logic [3:0]       last_seen;
    logic [3:0]       last_exec;
    logic             err_sticky;
    err_e             err_code;
    logic [SEL_W-1:0] rb_sel;
    logic [15:0]      rb_data;

    assign srst    = in_r[RST_BIT];
    assign cmd_evt = (state == S_IDLE) && (in_r != prev_r) && (in_r[CMD_LSB +: CMD_W] != IDLE);

    // Words that change while busy are not queued; the newest non-idle word wins at execute time.
    assign exec_w  = (in_r[CMD_LSB +: CMD_W] != IDLE) ? in_r : lat_r;
    assign cmd     = exec_w[CMD_LSB +: CMD_W];
    assign sel     = exec_w[SEL_LSB +: SEL_W];
    assign sel_bad = {1'b0, sel} >= N_CH_L;

    always_comb begin
        sel_hot = '0;
        for (int unsigned k = 0; k < N_CH; k++)
            sel_hot[k] = (sel == k[SEL_W-1:0]);
    end

    always_comb begin
        wr_en   = '0;
        commit  = 1'b0;
        clr_all = 1'b0;
        ok      = 1'b0;
        err     = 1'b0;
        err_nxt = ERR_NONE;
        get_en  = 1'b0;
        if (state == S_EXEC) begin
            case (cmd)
                SET: begin
                    if (sel_bad) begin
                        err     = 1'b1;
                        err_nxt = ERR_SEL;
                    end else begin
                        ok    = 1'b1;
                        wr_en = sel_hot;
                        if (|(pending_o & sel_hot)) begin
                            err     = 1'b1;
                            err_nxt = ERR_DOUBLE;
                        end
                    end
                end
                GET: begin
                    if (sel_bad) begin
                        err     = 1'b1;
                        err_nxt = ERR_SEL;
                    end else begin
                        ok     = 1'b1;
                        get_en = 1'b1;
                    end
                end
                CLR: begin
                    ok      = 1'b1;
                    clr_all = 1'b1;
                end
                STROBE: begin
                    ok     = 1'b1;
                    commit = 1'b1;
                end
                IDLE: ;
                default: begin
                    err     = 1'b1;
                    err_nxt = ERR_UNKNOWN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            in_r <= '0;
        else
            in_r <= axi_from_ps_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r     <= '0;
            lat_r      <= '0;
            state      <= S_IDLE;
            last_seen  <= '0;
            last_exec  <= '0;
            err_sticky <= 1'b0;
            err_code   <= ERR_NONE;
            rb_sel     <= '0;
        end else if (srst) begin
            prev_r     <= '0;
            lat_r      <= '0;
            state      <= S_IDLE;
            last_seen  <= '0;
            last_exec  <= '0;
            err_sticky <= 1'b0;
            err_code   <= ERR_NONE;
            rb_sel     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    prev_r <= in_r;
                    if (cmd_evt) begin
                        lat_r <= in_r;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    prev_r    <= exec_w;
                    state     <= S_ACK;
                    last_seen <= cmd;
                    if (ok)
                        last_exec <= cmd;
                    if (err) begin
                        err_sticky <= 1'b1;
                        err_code   <= err_nxt;
                    end
                    if (get_en)
                        rb_sel <= sel;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pdh_cmd_chan #(.DATA_W(DATA_W)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .srst    (srst),
            .wr_en   (wr_en[k]),
            .commit  (commit),
            .clr     (clr_all),
            .data    (exec_w[DATA_W-1:0]),
            .live    (ch_data_o[k*DATA_W +: DATA_W]),
            .pending (pending_o[k]),
            .update  (ch_update_o[k])
        );
    end

    always_comb begin
        rb_data = '0;
        for (int unsigned k = 0; k < N_CH; k++)
            if (rb_sel == k[SEL_W-1:0])
                rb_data[DATA_W-1:0] = ch_data_o[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            axi_to_ps_o <= '0;
        else if (srst)
            axi_to_ps_o <= '0;
        else
            axi_to_ps_o <= {last_seen, last_exec, |pending_o, err_sticky, err_code,
                            1'b0, rb_sel, rb_data};
    end

endmodule

// File: tb/tb_pdh_cmd_bank.sv
// Directed bench for pdh_cmd_bank (N_CH=4, DATA_W=16) with hand-computed expectations.
module tb_pdh_cmd_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] axi_from_ps_i;
    logic [31:0] axi_to_ps_o;
    logic [63:0] ch_data_o;
    logic [3:0]  ch_update_o;
    logic [3:0]  pending_o;

    int n_checks = 0;
    int n_pass   = 0;

    pdh_cmd_bank #(.N_CH(4), .DATA_W(16), .SEL_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .axi_from_ps_i (axi_from_ps_i),
        .axi_to_ps_o   (axi_to_ps_o),
        .ch_data_o     (ch_data_o),
        .ch_update_o   (ch_update_o),
        .pending_o     (pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [2:0] s, input logic [15:0] d);
        return {1'b0, c, s, 8'h00, d};
    endfunction

    initial begin
        logic [31:0] st;
        logic [3:0]  upd_seen;

        rst = 1'b1;
        axi_from_ps_i = '0;
        step(3);
        rst = 1'b0;
        step(2);

        // Reset asserted asynchronously in the middle of a SET
        axi_from_ps_i = mk(4'h1, 3'd1, 16'hBEEF); step(4);
        axi_from_ps_i = mk(4'hE, 3'd0, 16'h0000); step(4);
        chk("pre_rst_live", ch_data_o, 64'h0000_0000_BEEF_0000);
        axi_from_ps_i = mk(4'h1, 3'd2, 16'h0F0F); step(3);
        chk("pre_rst_pend", 64'(pending_o), 64'h4);
        #2 rst = 1'b1;
        #1;
        chk("rst_live",   ch_data_o, 64'h0);
        chk("rst_pend",   64'(pending_o), 64'h0);
        chk("rst_status", 64'(axi_to_ps_o), 64'h0);
        axi_from_ps_i = '0;
        step(2);
        rst = 1'b0;
        step(5);
        chk("idle_live",   ch_data_o, 64'h0);
        chk("idle_pend",   64'(pending_o), 64'h0);
        chk("idle_status", 64'(axi_to_ps_o), 64'h0);
        chk("idle_upd",    64'(ch_update_o), 64'h0);

        // Two SETs then a STROBE committing both on one edge
        axi_from_ps_i = mk(4'h1, 3'd1, 16'hA5A5); step(4);
        axi_from_ps_i = mk(4'h1, 3'd3, 16'h1234); step(4);
        chk("set_pend", 64'(pending_o), 64'hA);
        chk("set_live", ch_data_o, 64'h0);
        st = axi_to_ps_o;
        chk("set_anypend", 64'(st[23]), 64'h1);
        axi_from_ps_i = mk(4'hE, 3'd0, 16'h0000); step(2);
        chk("strobe_early_upd",  64'(ch_update_o), 64'h0);
        chk("strobe_early_live", ch_data_o, 64'h0);
        step(1);
        chk("strobe_upd",  64'(ch_update_o), 64'hA);
        chk("strobe_live", ch_data_o, 64'h1234_0000_A5A5_0000);
        chk("strobe_pend", 64'(pending_o), 64'h0);
        step(1);
        chk("strobe_upd_drop", 64'(ch_update_o), 64'h0);
        axi_from_ps_i = mk(4'h2, 3'd3, 16'h0000); step(4);
        st = axi_to_ps_o;
        chk("get_rbdata", 64'(st[15:0]), 64'h1234);
        chk("get_seen",   64'(st[31:28]), 64'h2);
        chk("get_exec",   64'(st[27:24]), 64'h2);
        chk("get_status", 64'(axi_to_ps_o), 64'h2203_1234);

        // Held word executes once; re-execution would raise the double-SET error
        axi_from_ps_i = mk(4'h1, 3'd0, 16'h00FF); step(50);
        st = axi_to_ps_o;
        chk("hold_pend", 64'(pending_o), 64'h1);
        chk("hold_flags", 64'(st[23:20]), 64'h8);
        axi_from_ps_i = mk(4'hE, 3'd0, 16'h0000); step(5);
        chk("hold_commit", ch_data_o, 64'h1234_0000_A5A5_00FF);
        axi_from_ps_i = '0; step(3);
        axi_from_ps_i = mk(4'h1, 3'd0, 16'h00FF); step(4);
        st = axi_to_ps_o;
        chk("reset_pend", 64'(pending_o), 64'h1);
        chk("reset_noerr", 64'(st[22:20]), 64'h0);
        axi_from_ps_i = mk(4'h3, 3'd0, 16'h0000); step(4);
        chk("clr_pend", 64'(pending_o), 64'h0);

        // Error paths
        axi_from_ps_i = mk(4'h7, 3'd0, 16'h0000); step(4);
        st = axi_to_ps_o;
        chk("err_unknown", 64'(st[31:20]), 64'h735);
        axi_from_ps_i = mk(4'h1, 3'd5, 16'hDEAD); step(4);
        st = axi_to_ps_o;
        chk("err_sel", 64'(st[31:20]), 64'h136);
        chk("err_sel_pend", 64'(pending_o), 64'h0);
        chk("err_sel_live", ch_data_o, 64'h1234_0000_A5A5_00FF);
        axi_from_ps_i = mk(4'h1, 3'd2, 16'h1111); step(4);
        axi_from_ps_i = mk(4'h1, 3'd2, 16'h2222); step(4);
        st = axi_to_ps_o;
        chk("err_dbl_code", 64'(st[22:20]), 64'h7);
        chk("err_dbl_pend", 64'(pending_o), 64'h4);
        axi_from_ps_i = mk(4'hE, 3'd0, 16'h0000); step(5);
        chk("err_dbl_live", ch_data_o, 64'h1234_2222_A5A5_00FF);

        // Soft reset clears everything, sticky error included
        axi_from_ps_i = 32'h8000_0000; step(2);
        chk("srst_live",   ch_data_o, 64'h0);
        chk("srst_status", 64'(axi_to_ps_o), 64'h0);
        step(4);
        chk("srst_pend", 64'(pending_o), 64'h0);
        axi_from_ps_i = '0; step(3);
        chk("srst_rel_status", 64'(axi_to_ps_o), 64'h0);
        axi_from_ps_i = mk(4'hE, 3'd0, 16'h0000);
        upd_seen = '0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            upd_seen = upd_seen | ch_update_o;
        end
        chk("empty_strobe_upd", 64'(upd_seen), 64'h0);
        chk("empty_strobe_status", 64'(axi_to_ps_o), 64'hEE00_0000);

        // Word changes every cycle; the newest SET is the one executed
        axi_from_ps_i = mk(4'h1, 3'd0, 16'h0001); step(1);
        axi_from_ps_i = mk(4'h1, 3'd0, 16'h0002); step(1);
        axi_from_ps_i = mk(4'hE, 3'd0, 16'h0000); step(8);
        chk("b2b_live", ch_data_o, 64'h0000_0000_0000_0002);
        chk("b2b_pend", 64'(pending_o), 64'h0);
        st = axi_to_ps_o;
        chk("b2b_exec", 64'(st[27:24]), 64'hE);
        chk("b2b_noX", 64'($isunknown({axi_to_ps_o, ch_data_o, ch_update_o, pending_o})), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
